// File: rtl/atm_pkg.sv
// Shared key codes, FSM state encoding and error-source tags for the ATM keypad host.
package atm_pkg;

  localparam logic [3:0] KEY_ENTER    = 4'hA;
  localparam logic [3:0] KEY_CANCEL   = 4'hB;
  localparam logic [3:0] KEY_WITHDRAW = 4'hC;
  localparam logic [3:0] KEY_BALANCE  = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIN_ENTRY,
    ST_PIN_CHECK,
    ST_MENU,
    ST_AMT_ENTRY,
    ST_WD_REQ,
    ST_BAL_REQ,
    ST_LOCKED
  } state_e;

  // ERR_ENTRY: short PIN, rejected amount digit or zero amount; ERR_RESPONSE: refusal or timeout.
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ENTRY,
    ERR_PIN,
    ERR_RESPONSE
  } err_src_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_keypad_host_if.sv
// Handshake between the keypad host (master) and atm_fsm (slave).
interface atm_keypad_host_if #(
  parameter int AMT_W = 16
);
  logic             confirm;
  logic             pin_right;
  logic             operation;
  logic             bank_type;
  logic [AMT_W-1:0] withdraw_amt;
  logic             allow_transaction;
  logic             show_bal;
  logic             transaction_done;

  modport master (
    output confirm, pin_right, operation, bank_type, withdraw_amt,
    input  allow_transaction, show_bal, transaction_done
  );

  modport slave (
    input  confirm, pin_right, operation, bank_type, withdraw_amt,
    output allow_transaction, show_bal, transaction_done
  );
endinterface

// File: rtl/atm_bcd_accum.sv
// Decimal amount accumulator: value = value*10 + digit, refusing digits that would overflow
// AMT_W bits or exceed AMT_DIGITS entered digits.
module atm_bcd_accum #(
  parameter int AMT_W      = 16,
  parameter int AMT_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic [AMT_W-1:0] value,
  output logic             reject
);
  localparam int CNT_W = $clog2(AMT_DIGITS + 1);

  logic [CNT_W-1:0] count;
  logic [AMT_W+3:0] next_val;

  // Four guard bits hold value*10+9 so overflow shows up in the top nibble.
  assign next_val = {4'b0, value} * (AMT_W+4)'(10) + (AMT_W+4)'(digit);
  assign reject   = digit_valid && ((count == CNT_W'(AMT_DIGITS)) || (|next_val[AMT_W+3:AMT_W]));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (digit_valid && !reject) begin
      value <= next_val[AMT_W-1:0];
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/atm_keypad_host.sv
// Keypad-side initiator for atm_fsm: PIN check with lockout, amount entry, request handshake.
// Define ATM_HOST_TIMEOUT_EN to abandon requests that see no response within TIMEOUT_CYC cycles.
module atm_keypad_host
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4,
  parameter int AMT_W      = 16,
  parameter int AMT_DIGITS = 5,
  parameter int PIN_TRIES  = 3
`ifdef ATM_HOST_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1000
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic [4*PIN_DIGITS-1:0] stored_pin,
  input  logic                    card_bank,
  atm_keypad_host_if.master       atm,
  output logic                    card_locked,
  output logic                    err
);
  localparam int PIN_W  = 4 * PIN_DIGITS;
  localparam int PCNT_W = $clog2(PIN_DIGITS + 1);
  localparam int TRY_W  = $clog2(PIN_TRIES + 1);

  state_e            state;
  err_src_e          err_src;
  logic [PIN_W-1:0]  pin_sr;
  logic [PCNT_W-1:0] pin_cnt;
  logic [TRY_W-1:0]  tries;
  logic              req_first;
  logic              key_digit, cancel_key, acc_clear, acc_valid, acc_reject;
  logic              req_resp, req_fail, timed_out;
  logic [AMT_W-1:0]  acc_value;

  assign key_digit  = key_valid && is_digit(key_code);
  assign cancel_key = key_valid && (key_code == KEY_CANCEL) &&
                      (state inside {ST_IDLE, ST_PIN_ENTRY, ST_MENU, ST_AMT_ENTRY});
  assign acc_clear  = cancel_key || (key_valid && state == ST_MENU && key_code == KEY_WITHDRAW);
  assign acc_valid  = key_digit && state == ST_AMT_ENTRY;
  assign err        = (err_src != ERR_NONE);

  // Refusal is only trusted once atm_fsm has had a cycle to see confirm.
  assign req_resp = (state == ST_WD_REQ && atm.transaction_done) || (state == ST_BAL_REQ && atm.show_bal);
  assign req_fail = !req_resp &&
                    ((state == ST_WD_REQ && !req_first && !atm.allow_transaction) || timed_out);

`ifdef ATM_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] req_cnt;

  assign timed_out = (state inside {ST_WD_REQ, ST_BAL_REQ}) && (req_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_cnt <= '0;
    else        req_cnt <= (state inside {ST_WD_REQ, ST_BAL_REQ}) ? req_cnt + 1'b1 : '0;
  end
`else
  assign timed_out = 1'b0;
`endif

  atm_bcd_accum #(.AMT_W(AMT_W), .AMT_DIGITS(AMT_DIGITS)) u_amt (
    .clk(clk), .rst_n(rst_n), .clear(acc_clear), .digit_valid(acc_valid),
    .digit(key_code), .value(acc_value), .reject(acc_reject)
  );

  // NOTE: outputs sit in the async-reset branch, so confirm drops the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      err_src          <= ERR_NONE;
      pin_sr           <= '0;
      pin_cnt          <= '0;
      tries            <= '0;
      req_first        <= 1'b0;
      card_locked      <= 1'b0;
      atm.confirm      <= 1'b0;
      atm.pin_right    <= 1'b0;
      atm.operation    <= 1'b0;
      atm.bank_type    <= 1'b0;
      atm.withdraw_amt <= '0;
    end else begin
      err_src   <= ERR_NONE;
      req_first <= 1'b0;
      if (cancel_key) begin
        state         <= ST_IDLE;
        atm.pin_right <= 1'b0;
        pin_sr        <= '0;
        pin_cnt       <= '0;
      end else begin
        case (state)
          ST_IDLE: if (key_digit) begin
            pin_sr  <= PIN_W'(key_code);
            pin_cnt <= PCNT_W'(1);
            state   <= ST_PIN_ENTRY;
          end
          ST_PIN_ENTRY: begin
            if (key_digit && pin_cnt < PCNT_W'(PIN_DIGITS)) begin
              pin_sr  <= {pin_sr[PIN_W-5:0], key_code};
              pin_cnt <= pin_cnt + 1'b1;
            end else if (key_valid && key_code == KEY_ENTER) begin
              if (pin_cnt == PCNT_W'(PIN_DIGITS)) begin
                state <= ST_PIN_CHECK;
              end else begin
                err_src <= ERR_ENTRY;
                pin_sr  <= '0;
                pin_cnt <= '0;
              end
            end
          end
          ST_PIN_CHECK: begin
            pin_sr  <= '0;
            pin_cnt <= '0;
            if (pin_sr == stored_pin) begin
              state         <= ST_MENU;
              atm.pin_right <= 1'b1;
              atm.bank_type <= card_bank;
              tries         <= '0;
            end else begin
              err_src <= ERR_PIN;
              tries   <= tries + 1'b1;
              if (tries == TRY_W'(PIN_TRIES - 1)) begin
                state       <= ST_LOCKED;
                card_locked <= 1'b1;
              end else begin
                state <= ST_PIN_ENTRY;
              end
            end
          end
          ST_MENU: begin
            if (key_valid && key_code == KEY_BALANCE) begin
              state         <= ST_BAL_REQ;
              atm.operation <= 1'b0;
              atm.confirm   <= 1'b1;
              req_first     <= 1'b1;
            end else if (key_valid && key_code == KEY_WITHDRAW) begin
              state <= ST_AMT_ENTRY;
            end
          end
          ST_AMT_ENTRY: begin
            if (acc_valid && acc_reject) begin
              err_src <= ERR_ENTRY;
            end else if (key_valid && key_code == KEY_ENTER) begin
              if (acc_value == '0) begin
                err_src <= ERR_ENTRY;
              end else begin
                state            <= ST_WD_REQ;
                atm.withdraw_amt <= acc_value;
                atm.operation    <= 1'b1;
                atm.confirm      <= 1'b1;
                req_first        <= 1'b1;
              end
            end
          end
          ST_WD_REQ, ST_BAL_REQ: if (req_resp || req_fail) begin
            state         <= ST_MENU;
            atm.confirm   <= 1'b0;
            atm.bank_type <= card_bank;
            if (req_fail) err_src <= ERR_RESPONSE;
          end
          ST_LOCKED: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_keypad_host.sv
// Randomized self-checking bench for atm_keypad_host against a session-level behavioural model.
module tb_atm_keypad_host;
  import atm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] stored_pin;
  logic        card_bank;
  logic        card_locked, err;

  atm_keypad_host_if #(.AMT_W(16)) atm ();

  atm_keypad_host dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .stored_pin(stored_pin), .card_bank(card_bank), .atm(atm),
    .card_locked(card_locked), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Session model: what the customer has achieved so far, not how the FSM encodes it.
  bit m_locked, m_authed, m_started, m_in_amt, m_op;
  int m_req;       // 0 none, 1 withdraw pending, 2 balance pending
  int m_q[$];      // PIN digits typed so far
  int m_tries, m_amt, m_amt_n, m_wd_amt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pin_digit(input int i);
    return int'(stored_pin[4*(3-i) +: 4]);
  endfunction

  task automatic model_clear();
    m_locked = 0; m_authed = 0; m_started = 0; m_in_amt = 0; m_op = 0;
    m_req = 0; m_q.delete(); m_tries = 0; m_amt = 0; m_amt_n = 0; m_wd_amt = 0;
  endtask

  task automatic model_key(input int k, output bit e_now, output bit e_late);
    bit dig = (k <= 9);
    e_now = 0;
    e_late = 0;
    if (m_locked || m_req != 0) return;
    if (k == int'(KEY_CANCEL)) begin
      m_started = 0; m_authed = 0; m_in_amt = 0; m_q.delete(); m_amt = 0; m_amt_n = 0;
      return;
    end
    if (!m_authed) begin
      if (dig) begin
        if (!m_started) begin
          m_started = 1; m_q.delete(); m_q.push_back(k);
        end else if (m_q.size() < 4) begin
          m_q.push_back(k);
        end
      end else if (k == int'(KEY_ENTER) && m_started) begin
        if (m_q.size() < 4) begin
          e_now = 1; m_q.delete();
        end else begin
          bit ok = 1;
          for (int i = 0; i < 4; i++) if (m_q[i] != pin_digit(i)) ok = 0;
          m_q.delete();
          if (ok) begin
            m_authed = 1; m_tries = 0;
          end else begin
            e_late = 1; m_tries++;
            if (m_tries == 3) m_locked = 1;
          end
        end
      end
    end else if (!m_in_amt) begin
      if (k == int'(KEY_BALANCE)) begin
        m_req = 2; m_op = 0;
      end else if (k == int'(KEY_WITHDRAW)) begin
        m_in_amt = 1; m_amt = 0; m_amt_n = 0;
      end
    end else begin
      if (dig) begin
        if (m_amt_n == 5 || m_amt * 10 + k > 65535) e_now = 1;
        else begin m_amt = m_amt * 10 + k; m_amt_n++; end
      end else if (k == int'(KEY_ENTER)) begin
        if (m_amt == 0) e_now = 1;
        else begin m_req = 1; m_op = 1; m_wd_amt = m_amt; m_in_amt = 0; end
      end
    end
  endtask

  task automatic check_outputs();
    check("pin_right", atm.pin_right, m_authed);
    check("card_locked", card_locked, m_locked);
    check("confirm", atm.confirm, m_req != 0);
    if (m_req != 0) check("operation", atm.operation, m_op);
    if (m_req == 1) check("withdraw_amt", atm.withdraw_amt, m_wd_amt);
    if (m_authed)   check("bank_type", atm.bank_type, card_bank);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    atm.allow_transaction = 1'b1;
    atm.show_bal = 1'b0;
    atm.transaction_done = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_confirm", atm.confirm, 0);
    check("rst_pin_right", atm.pin_right, 0);
    check("rst_operation", atm.operation, 0);
    check("rst_bank_type", atm.bank_type, 0);
    check("rst_amt", atm.withdraw_amt, 0);
    check("rst_locked", card_locked, 0);
    check("rst_err", err, 0);
  endtask

  // One key strobe; err checked the cycle after the key and once more for the PIN-check cycle.
  task automatic press(input int k);
    bit e_now, e_late;
    model_key(k, e_now, e_late);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k[3:0];
    @(negedge clk);
    key_valid = 1'b0;
    check("err_now", err, e_now);
    @(negedge clk);
    check("err_late", err, e_late);
    check_outputs();
  endtask

  task automatic press_hex(input logic [63:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) press(int'(seq[4*i +: 4]));
  endtask

  // mode: 0 random outcome, 1 success, 2 refusal (withdraw only)
  task automatic respond(input int mode);
    int lat;
    bit refuse;
    if ($urandom_range(0, 1) == 1) press(int'($urandom_range(0, 15)));
    lat = int'($urandom_range(0, 3));
    repeat (lat) begin
      @(negedge clk);
      check("hold_confirm", atm.confirm, 1);
      if (m_req == 1) check("hold_amt", atm.withdraw_amt, m_wd_amt);
    end
    refuse = (m_req == 1) && (mode == 2 || (mode == 0 && $urandom_range(0, 3) == 0));
    @(negedge clk);
    if (m_req == 2)  atm.show_bal = 1'b1;
    else if (refuse) atm.allow_transaction = 1'b0;
    else             atm.transaction_done = 1'b1;
    @(negedge clk);
    atm.show_bal = 1'b0;
    atm.allow_transaction = 1'b1;
    atm.transaction_done = 1'b0;
    m_req = 0;
    check("resp_err", err, refuse);
    check_outputs();
  endtask

  function automatic int gen_key();
    int r = int'($urandom_range(0, 99));
    if (m_locked) return int'($urandom_range(0, 15));
    if (!m_authed) begin
      if (r < 70) begin
        if (m_started && m_q.size() >= 4) return int'(KEY_ENTER);
        return pin_digit(m_started ? m_q.size() : 0);
      end
      if (r < 85) return int'($urandom_range(0, 9));
      if (r < 92) return int'(KEY_ENTER);
      if (r < 97) return int'($urandom_range(12, 15));
      return int'(KEY_CANCEL);
    end
    if (!m_in_amt) begin
      if (r < 45) return int'(KEY_WITHDRAW);
      if (r < 85) return int'(KEY_BALANCE);
      if (r < 95) return int'($urandom_range(10, 15));
      return int'(KEY_CANCEL);
    end
    if (r < 75) return int'($urandom_range(0, 9));
    if (r < 93) return int'(KEY_ENTER);
    return int'($urandom_range(10, 15));
  endfunction

  initial begin
    stored_pin = 16'h1234;
    card_bank  = 1'b1;
    do_reset();

    press_hex(64'h12A, 3);          // short PIN
    press_hex(64'h1234A, 5);        // correct PIN
    press(int'(KEY_BALANCE));
    respond(1);
    press_hex(64'hC10000A, 7);      // 10000
    respond(1);
    press_hex(64'hC70000A, 7);      // fifth digit overflows, 7000 requested
    respond(2);
    press_hex(64'hC0A, 3);          // zero amount
    press_hex(64'h5A, 2);
`ifdef ATM_HOST_TIMEOUT_EN
    begin
      int n = 0;
      while (atm.confirm && n < 1100) begin
        @(negedge clk);
        n++;
      end
      check("to_cycles", n, 999);
      check("to_err", err, 1);
      m_req = 0;
      check_outputs();
    end
`else
    respond(1);
`endif
    press_hex(64'hC42A, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_confirm", atm.confirm, 0);

    stored_pin = 16'h1234;
    card_bank  = 1'b0;
    do_reset();
    press_hex(64'h0000A0000A0000A, 15);
    press_hex(64'h1234AD, 6);       // ignored once locked

    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < 4; i++) stored_pin[4*i +: 4] = 4'($urandom_range(0, 9));
      card_bank = 1'($urandom_range(0, 1));
      do_reset();
      for (int n = 0; n < 40; n++) begin
        press(gen_key());
        if (m_req != 0) respond(0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
